// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// One write attempt in flight (IDLE -> WRITE -> CHECK); failed attempts retry up to MAX_RETRY.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_done_o,
    output logic [NUM_REQ-1:0]              req_err_o,
    output logic                            fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]           fifo_data_in_o,
    input  logic                            fifo_full_i,
    input  logic                            fifo_wr_ack_i,
    input  logic                            fifo_overflow_i,
    output logic                            busy_o,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id_o,
    output logic [15:0]                     wr_count_o,
    output logic [7:0]                      err_count_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int RW  = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, WRITE, CHECK} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_q, rr_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [NUM_REQ-1:0]    err_q, err_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  win_found;
    logic [IDW-1:0]        win_idx;
    logic [IDW-1:0]        cand;
    logic [IDW-1:0]        next_ptr;

    // Ack alone decides success; overflow only matters through the absence of ack.
    logic unused_overflow;
    assign unused_overflow = fifo_overflow_i;

    // First asserted request at or after rr_q, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = IDW'((int'(rr_q) + off) % NUM_REQ);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign next_ptr = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        rr_d        = rr_q;
        retry_d     = retry_q;
        wr_en_d     = 1'b0;
        data_d      = data_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = '0;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                if (win_found && !fifo_full_i) begin
                    grant_d = win_idx;
                    data_d  = req_data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    wr_en_d = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: state_d = CHECK;
            CHECK: begin
                state_d = IDLE;
                if (fifo_wr_ack_i) begin
                    done_d[grant_q] = 1'b1;
                    wr_count_d      = (wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
                    retry_d         = '0;
                    rr_d            = next_ptr;
                end else if (retry_q == RW'(MAX_RETRY - 1)) begin
                    err_d[grant_q]  = 1'b1;
                    err_count_d     = (err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
                    retry_d         = '0;
                    rr_d            = next_ptr;
                end else begin
                    // rr_q stays put so the same producer is re-granted while still valid.
                    retry_d         = retry_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            retry_q     <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            retry_q     <= retry_d;
            wr_en_q     <= wr_en_d;
            data_q      <= data_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign req_done_o     = done_q;
    assign req_err_o      = err_q;
    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_data_in_o = data_q;
    assign busy_o         = (state_q != IDLE);
    assign grant_id_o     = grant_q;
    assign wr_count_o     = wr_count_q;
    assign err_count_o    = err_count_q;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of producers sharing the FIFO write port (2..8).
REQ-002 Parameter DATA_WIDTH, default 16, FIFO data width.
REQ-003 Parameter MAX_RETRY, default 3, failed write attempts before a request is dropped.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-producer write request; held until req_done or req_err.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  per-producer data, slice i = producer i.
REQ-008 req_done  output  NUM_REQ  one-cycle pulse: producer's word written (FIFO wr_ack seen).
REQ-009 req_err  output  NUM_REQ  one-cycle pulse: producer's word dropped after MAX_RETRY failures.
REQ-010 fifo_wr_en  output  1  FIFO write enable, registered.
REQ-011 fifo_data_in  output  DATA_WIDTH  FIFO write data, registered.
REQ-012 fifo_full  input  1  FIFO full flag.
REQ-013 fifo_wr_ack  input  1  FIFO registered write acknowledge.
REQ-014 fifo_overflow  input  1  FIFO registered overflow flag.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 grant_id  output  clog2(NUM_REQ)  index of producer currently served; holds last value in IDLE.
REQ-017 wr_count  output  16  count of successful writes, saturating at 16'hFFFF.
REQ-018 err_count  output  8  count of dropped requests, saturating at 8'hFF.

Function
REQ-019 FSM states IDLE, WRITE, CHECK; exactly one write attempt in flight.
REQ-020 IDLE: if any req_valid and fifo_full=0, select winner by round-robin from pointer rr_ptr (first asserted index at or after rr_ptr, wrapping NUM_REQ-1 -> 0), register grant_id, fifo_data_in <= req_data[winner], fifo_wr_en <= 1, go WRITE.
REQ-021 IDLE with fifo_full=1: no grant, fifo_wr_en stays 0, rr_ptr unchanged.
REQ-022 WRITE: lasts one cycle; fifo_wr_en <= 0; go CHECK.
REQ-023 CHECK: sample fifo_wr_ack; if 1 -> req_done[grant_id] pulses next cycle, wr_count++, retry count cleared, rr_ptr <= grant_id+1 (mod NUM_REQ), go IDLE.
REQ-024 CHECK with fifo_wr_ack=0 (overflow or no ack): retry count++; if it reaches MAX_RETRY -> req_err[grant_id] pulses, err_count++, retry count cleared, rr_ptr <= grant_id+1; else rr_ptr unchanged so the same producer wins next grant if still valid; go IDLE.
REQ-025 Latency: req_valid sampled at edge k in IDLE -> fifo_wr_en high k+1..k+2 -> req_done/req_err high for one cycle after edge k+2; throughput one attempt per 3 cycles.
REQ-026 Producer dropping req_valid before done: current attempt completes; done/err pulse still issued; no effect on data already registered.
REQ-027 fifo_wr_ack and fifo_overflow both 1 in CHECK: treated as success.
REQ-028 At most one bit of req_done|req_err high in any cycle; fifo_wr_en never high two consecutive cycles.
REQ-029 Counters saturate, never wrap.

Reset
REQ-030 rst=1 at an edge: state IDLE, rr_ptr 0, retry count 0, fifo_wr_en 0, fifo_data_in 0, req_done 0, req_err 0, busy 0, grant_id 0, wr_count 0, err_count 0; overrides any in-flight attempt without done/err pulse.

Verification
REQ-031 Single producer: req_valid=4'b0010, req_data[1]=16'hA5A5, FIFO acks -> fifo_wr_en one cycle with 16'hA5A5, req_done=4'b0010 two cycles later, wr_count=1.
REQ-032 All four valid continuously, FIFO always acks -> grants in order 0,1,2,3,0; wr_count=5 after 15 cycles.
REQ-033 fifo_full=1 with req_valid=4'b1111 for 10 cycles -> fifo_wr_en stays 0, busy 0; full drops -> producer 0 granted.
REQ-034 Producer 2 only, FIFO returns overflow (no ack) every attempt -> three attempts, req_err=4'b0100 pulse, err_count=1, next grant goes to producer 3 if valid.
REQ-035 rst asserted in CHECK state -> next cycle all outputs 0, no req_done pulse, next grant from producer 0.
REQ-036 Force wr_count to 16'hFFFF via long run, one more ack -> wr_count remains 16'hFFFF.
